// File: rtl/assoc_cache.sv
// Set-associative write-back, write-allocate cache with true-LRU replacement.
// Defining ASSOC_CACHE_STATS_EN adds hit_cnt_o / miss_cnt_o request counters.
module assoc_cache #(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned SETS       = 8,
  parameter int unsigned LINE_WORDS = 4,
  localparam int unsigned LINE_BITS = 32 * LINE_WORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic                 wen_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           be_i,
  output logic [31:0]          rdata_o,
  output logic                 ready_o,
  output logic                 mem_valid_o,
  output logic                 mem_wen_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic [LINE_BITS-1:0] mem_rdata_i,
  input  logic                 mem_ready_i
`ifdef ASSOC_CACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  localparam int unsigned OFF_W  = $clog2(LINE_WORDS * 4);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = 32 - OFF_W - IDX_W;
  localparam int unsigned WORD_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {StIdle, StComp, StWback, StRefill} state_e;

  state_e state_q, state_d;

  logic                 req_wen_q;
  logic [31:2]          req_addr_q;
  logic [31:0]          req_wdata_q;
  logic [3:0]           req_be_q;
  logic [WAY_W-1:0]     victim_q;
  logic                 first_q;

  logic [SETS-1:0]      valid_q [WAYS];
  logic [SETS-1:0]      dirty_q [WAYS];
  logic [TAG_W-1:0]     tag_q   [WAYS][SETS];
  logic [LINE_BITS-1:0] line_q  [WAYS][SETS];

  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic [WORD_W-1:0]    word_sel;
  logic                 hit, inv_found, comp_hit;
  logic [WAY_W-1:0]     hit_way, inv_way, lru_way, victim_d;
  logic                 unused_addr;

  assign unused_addr = ^addr_i[1:0];
  assign idx         = req_addr_q[OFF_W +: IDX_W];
  assign tag         = req_addr_q[31 -: TAG_W];
  assign word_sel    = (LINE_WORDS > 1) ? req_addr_q[2 +: WORD_W] : '0;
  assign comp_hit    = (state_q == StComp) && hit && !rst;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[w][idx]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim_d = inv_found ? inv_way : lru_way;
  end

  if (WAYS > 1) begin : g_lru
    // Per-set ages form a permutation; the oldest way holds age WAYS-1.
    logic [WAY_W-1:0] age_q [SETS][WAYS];

    always_comb begin
      lru_way = '0;
      for (int w = 0; w < WAYS; w++) begin
        if (age_q[idx][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++) begin
          for (int w = 0; w < WAYS; w++) age_q[s][w] <= WAY_W'(w);
        end
      end else if (comp_hit) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == hit_way) begin
            age_q[idx][w] <= '0;
          end else if (age_q[idx][w] < age_q[idx][hit_way]) begin
            age_q[idx][w] <= age_q[idx][w] + 1'b1;
          end
        end
      end
    end
  end else begin : g_dm
    assign lru_way = '0;
  end

  always_comb begin
    state_d     = state_q;
    ready_o     = 1'b0;
    rdata_o     = '0;
    mem_valid_o = 1'b0;
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    unique case (state_q)
      StIdle: if (valid_i) state_d = StComp;
      StComp: begin
        if (hit) begin
          ready_o = 1'b1;
          if (!req_wen_q) rdata_o = line_q[hit_way][idx][word_sel*32 +: 32];
          state_d = StIdle;
        end else begin
          state_d = dirty_q[victim_d][idx] ? StWback : StRefill;
        end
      end
      StWback: begin
        mem_valid_o = 1'b1;
        mem_wen_o   = 1'b1;
        mem_addr_o  = {tag_q[victim_q][idx], idx, {OFF_W{1'b0}}};
        mem_wdata_o = line_q[victim_q][idx];
        if (mem_ready_i) state_d = StRefill;
      end
      StRefill: begin
        mem_valid_o = 1'b1;
        mem_addr_o  = {req_addr_q[31:OFF_W], {OFF_W{1'b0}}};
        if (mem_ready_i) state_d = StComp;
      end
      default: state_d = StIdle;
    endcase
    if (rst) begin
      state_d     = StIdle;
      ready_o     = 1'b0;
      rdata_o     = '0;
      mem_valid_o = 1'b0;
      mem_wen_o   = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      req_wen_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_be_q    <= '0;
      victim_q    <= '0;
      first_q     <= 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && valid_i) begin
        req_wen_q   <= wen_i;
        req_addr_q  <= addr_i[31:2];
        req_wdata_q <= wdata_i;
        req_be_q    <= be_i;
        first_q     <= 1'b1;
      end
      if (state_q == StComp) begin
        if (hit) begin
          if (req_wen_q) begin
            for (int b = 0; b < 4; b++) begin
              if (req_be_q[b]) line_q[hit_way][idx][word_sel*32 + b*8 +: 8] <= req_wdata_q[b*8 +: 8];
            end
            dirty_q[hit_way][idx] <= 1'b1;
          end
        end else begin
          victim_q <= victim_d;
        end
      end
      if (state_q == StRefill && mem_ready_i) begin
        line_q[victim_q][idx]  <= mem_rdata_i;
        tag_q[victim_q][idx]   <= tag;
        valid_q[victim_q][idx] <= 1'b1;
        dirty_q[victim_q][idx] <= 1'b0;
        first_q                <= 1'b0;
      end
    end
  end

`ifdef ASSOC_CACHE_STATS_EN
  // Only the first COMP of a request counts; the post-refill replay does not.
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == StComp && first_q) begin
      if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      else     miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Scoreboard bench for assoc_cache (default parameters) with a fixed-pattern memory model.
// Counter checks are included when ASSOC_CACHE_STATS_EN is defined.
module tb_assoc_cache;
  localparam int LB = 128;

  logic          clk = 1'b0;
  logic          rst, valid_i, wen_i;
  logic [31:0]   addr_i, wdata_i, rdata_o, mem_addr_o;
  logic [3:0]    be_i;
  logic          ready_o, mem_valid_o, mem_wen_o, mem_ready_i;
  logic [LB-1:0] mem_wdata_o, mem_rdata_i;
`ifdef ASSOC_CACHE_STATS_EN
  logic [31:0]   hit_cnt_o, miss_cnt_o;
`endif

  always #5 clk = ~clk;

  assoc_cache dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .wen_i      (wen_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .be_i       (be_i),
    .rdata_o    (rdata_o),
    .ready_o    (ready_o),
    .mem_valid_o(mem_valid_o),
    .mem_wen_o  (mem_wen_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ready_i(mem_ready_i)
`ifdef ASSOC_CACHE_STATS_EN
    ,
    .hit_cnt_o  (hit_cnt_o),
    .miss_cnt_o (miss_cnt_o)
`endif
  );

  typedef struct packed {
    logic          wen;
    logic [31:0]   addr;
    logic [LB-1:0] data;
    logic          chk_data;
  } mreq_t;

  logic [31:0] exp_q[$];
  mreq_t       mem_q[$];
  int          checks = 0;
  int          failures = 0;
  int          mem_txn = 0;
  int          ready_cnt = 0;
  bit          hold_mem = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a, input int w);
    if (a == 32'h100) return 32'hDEADBEEF;
    return 32'h5A00_0000 | a | 32'(w);
  endfunction

  function automatic logic [LB-1:0] mem_line(input logic [31:0] a);
    logic [LB-1:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = mem_word(a, w);
    return l;
  endfunction

  task automatic chk(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic w, input logic [31:0] a, input logic [LB-1:0] d,
                         input logic c);
    mreq_t m;
    m.wen = w; m.addr = a; m.data = d; m.chk_data = c;
    mem_q.push_back(m);
  endtask

  task automatic req(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic [31:0] exp, output int lat);
    exp_q.push_back(exp);
    @(negedge clk);
    valid_i = 1'b1; wen_i = w; addr_i = a; wdata_i = d; be_i = b;
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 0;
    while (!ready_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 200) chk("req_timeout", 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic wait_mem_valid(input string name);
    int n = 0;
    while (!mem_valid_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk(name, 1'b1, 1'b0);
  endtask

  // CPU-side monitor: every ready_o pulse pops one expected load/store result.
  initial begin
    forever begin
      @(negedge clk);
      if (ready_o) begin
        ready_cnt++;
        if (exp_q.size() == 0) chk("unexpected_ready", 1'b1, 1'b0);
        else chk("rdata", rdata_o, exp_q.pop_front());
      end
    end
  end

  // Memory responder: answers after two wait cycles and checks each completed request.
  initial begin
    int    wait_cnt;
    mreq_t m;
    wait_cnt    = 0;
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (mem_ready_i) begin
        mem_ready_i = 1'b0;
      end else if (mem_valid_o && !hold_mem && !rst) begin
        if (wait_cnt < 2) begin
          wait_cnt++;
        end else begin
          wait_cnt    = 0;
          mem_rdata_i = mem_line(mem_addr_o);
          mem_ready_i = 1'b1;
          mem_txn++;
          if (mem_q.size() == 0) begin
            chk("unexpected_mem_req", 1'b1, 1'b0);
          end else begin
            m = mem_q.pop_front();
            chk("mem_wen", mem_wen_o, m.wen);
            chk("mem_addr", mem_addr_o, m.addr);
            if (m.chk_data) chk("mem_wdata", mem_wdata_o, m.data);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lat, n0, r0;
    logic [LB-1:0] wb;
    rst = 1'b1; valid_i = 1'b0; wen_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready_o, 1'b0);
    chk("rst_mem_valid", mem_valid_o, 1'b0);
    chk("rst_mem_wen", mem_wen_o, 1'b0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_wdata", mem_wdata_o, '0);
    @(negedge clk); rst = 1'b0;

    // Refill, repeated hit, partial store merge.
    exp_mem(1'b0, 32'h100, '0, 1'b0);
    req(1'b0, 32'h104, 32'h0, 4'h0, 32'hDEADBEEF, lat);
    chk("miss_lat_nonzero", lat > 0, 1'b1);
    req(1'b0, 32'h104, 32'h0, 4'h0, 32'hDEADBEEF, lat);
    chk("hit_lat", lat, 0);
    chk("hit_no_mem", mem_txn, 1);
    req(1'b1, 32'h100, 32'h11223344, 4'h3, 32'h0, lat);
    chk("store_hit_lat", lat, 0);
    req(1'b0, 32'h100, 32'h0, 4'h0, 32'hDEAD3344, lat);

    // LRU: fill set 0 (tag 1 dirty via store miss), touch tag 0, miss tag 4.
    do_reset();
    exp_mem(1'b0, 32'h000, '0, 1'b0);
    req(1'b0, 32'h000, 32'h0, 4'h0, 32'h5A000000, lat);
    exp_mem(1'b0, 32'h080, '0, 1'b0);
    req(1'b1, 32'h080, 32'hCAFEF00D, 4'hF, 32'h0, lat);
    exp_mem(1'b0, 32'h100, '0, 1'b0);
    req(1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, lat);
    exp_mem(1'b0, 32'h180, '0, 1'b0);
    req(1'b0, 32'h180, 32'h0, 4'h0, 32'h5A000180, lat);
    req(1'b0, 32'h000, 32'h0, 4'h0, 32'h5A000000, lat);
    chk("touch_hit_lat", lat, 0);
    wb = mem_line(32'h080);
    wb[31:0] = 32'hCAFEF00D;
    exp_mem(1'b1, 32'h080, wb, 1'b1);
    exp_mem(1'b0, 32'h200, '0, 1'b0);
    req(1'b0, 32'h204, 32'h0, 4'h0, 32'h5A000201, lat);
    exp_mem(1'b0, 32'h080, '0, 1'b0);
    req(1'b0, 32'h080, 32'h0, 4'h0, 32'h5A000080, lat);
    exp_mem(1'b0, 32'h100, '0, 1'b0);
    req(1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, lat);
    req(1'b0, 32'h204, 32'h0, 4'h0, 32'h5A000201, lat);
    chk("tag4_kept_hit_lat", lat, 0);

    // Reset while a writeback is stalled.
    do_reset();
    exp_mem(1'b0, 32'h000, '0, 1'b0);
    req(1'b1, 32'h000, 32'h01020304, 4'hF, 32'h0, lat);
    exp_mem(1'b0, 32'h080, '0, 1'b0);
    req(1'b0, 32'h080, 32'h0, 4'h0, 32'h5A000080, lat);
    exp_mem(1'b0, 32'h100, '0, 1'b0);
    req(1'b0, 32'h100, 32'h0, 4'h0, 32'hDEADBEEF, lat);
    exp_mem(1'b0, 32'h180, '0, 1'b0);
    req(1'b0, 32'h180, 32'h0, 4'h0, 32'h5A000180, lat);
    hold_mem = 1'b1;
    @(negedge clk);
    valid_i = 1'b1; wen_i = 1'b0; addr_i = 32'h200;
    @(posedge clk); #1;
    valid_i = 1'b0;
    wait_mem_valid("wback_timeout");
    wb = mem_line(32'h000);
    wb[31:0] = 32'h01020304;
    chk("wback_wen", mem_wen_o, 1'b1);
    chk("wback_addr", mem_addr_o, 32'h000);
    chk("wback_wdata", mem_wdata_o, wb);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_mem_valid", mem_valid_o, 1'b0);
    chk("abort_ready", ready_o, 1'b0);
    @(negedge clk); rst = 1'b0; hold_mem = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_idle_mem_valid", mem_valid_o, 1'b0);
    exp_mem(1'b0, 32'h000, '0, 1'b0);
    req(1'b0, 32'h000, 32'h0, 4'h0, 32'h5A000000, lat);
    chk("after_abort_miss", lat > 0, 1'b1);

    // Stalled refill: outputs stable, valid_i ignored.
    hold_mem = 1'b1;
    exp_mem(1'b0, 32'h300, '0, 1'b0);
    exp_q.push_back(32'h5A000300);
    @(negedge clk);
    valid_i = 1'b1; wen_i = 1'b0; addr_i = 32'h300;
    @(posedge clk); #1;
    valid_i = 1'b0;
    wait_mem_valid("refill_timeout");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      valid_i = 1'($urandom); wen_i = 1'($urandom); addr_i = $urandom;
      @(posedge clk); #1;
      chk("stall_mem_valid", mem_valid_o, 1'b1);
      chk("stall_mem_addr", mem_addr_o, 32'h300);
      chk("stall_mem_wen", mem_wen_o, 1'b0);
      chk("stall_ready", ready_o, 1'b0);
    end
    @(negedge clk);
    valid_i = 1'b0; hold_mem = 1'b0;
    lat = 0;
    while (!ready_o && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 100) chk("stall_done_timeout", 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("stall_no_extra_req", mem_valid_o, 1'b0);

    // valid_i held high: accepted every other cycle.
    r0 = ready_cnt;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h5A000301);
    @(negedge clk);
    valid_i = 1'b1; wen_i = 1'b0; addr_i = 32'h304;
    repeat (6) @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_ready_count", ready_cnt - r0, 3);

`ifdef ASSOC_CACHE_STATS_EN
    do_reset();
    chk("stats_rst_hit", hit_cnt_o, 32'd0);
    exp_mem(1'b0, 32'h400, '0, 1'b0);
    req(1'b0, 32'h400, 32'h0, 4'h0, 32'h5A000400, lat);
    req(1'b0, 32'h400, 32'h0, 4'h0, 32'h5A000400, lat);
    req(1'b0, 32'h404, 32'h0, 4'h0, 32'h5A000401, lat);
    chk("stats_hit_cnt", hit_cnt_o, 32'd2);
    chk("stats_miss_cnt", miss_cnt_o, 32'd1);
`endif

    n0 = mem_txn;
    repeat (5) @(posedge clk);
    #1;
    chk("quiet_end", mem_txn, n0);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("mem_q_empty", mem_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
